// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: issue/result bundle between the pipeline controller and the multiply/divide unit
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, input busy, done, div_by_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: bit-serial MULT/MULTU/DIV/DIVU on magnitudes with a shared ripple add/subtract stage
module mult_div_unit #(parameter int WIDTH = 32) (
  input logic            clk,
  input logic            rst_n,
  mult_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  localparam logic [5:0] LAST = 6'(WIDTH - 1);
  state_t               state, state_nx;
  logic                 is_div, neg_q, neg_r, dz;
  logic [5:0]           cnt;
  logic [2*WIDTH-1:0]   acc, prod;
  logic [WIDTH-1:0]     m, mag_a, mag_b, quo, rem, fix_hi, fix_lo, hi_q, lo_q;
  logic                 sa, sb, zero_div, done_q, dbz_q;
  logic [WIDTH:0]       add_x, add_y, add_s;
  logic [WIDTH+1:0]     c;
  assign sa       = ~bus.op[0] & bus.a[WIDTH-1];
  assign sb       = ~bus.op[0] & bus.b[WIDTH-1];
  assign mag_a    = sa ? -bus.a : bus.a;
  assign mag_b    = sb ? -bus.b : bus.b;
  assign zero_div = bus.op[1] && bus.b == '0;
  assign bus.busy        = state != IDLE;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  // Multiply adds the multiplicand when the low multiplier bit is set; divide subtracts the divisor from the shifted remainder
  always_comb begin
    add_x = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_y = is_div ? ~{1'b0, m} : (acc[0] ? {1'b0, m} : '0);
  end
  assign c[0] = is_div;
  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign add_s[i]  = add_x[i] ^ add_y[i] ^ c[i];
    assign c[i+1]    = (add_x[i] & add_y[i]) | (c[i] & (add_x[i] ^ add_y[i]));
  end
  // Sign correction applied on the way into HI/LO
  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_hi = dz ? m : is_div ? rem : prod[2*WIDTH-1:WIDTH];
    fix_lo = dz ? '1 : is_div ? quo : prod[WIDTH-1:0];
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Next state: a zero divisor goes straight to FIX so HI/LO land one edge after acceptance
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (bus.start ? (zero_div ? FIX : RUN) : IDLE)
             : state == RUN  ? (cnt == LAST ? FIX : RUN)
             : IDLE;
  end
  // Operand latch, per-cycle iteration, and result write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      m      <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (state == IDLE && bus.start) begin
        is_div <= bus.op[1];
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        dz     <= zero_div;
        cnt    <= '0;
        m      <= zero_div ? bus.a : bus.op[1] ? mag_b : mag_a;
        acc    <= zero_div ? '0 : {{WIDTH{1'b0}}, bus.op[1] ? mag_a : mag_b};
      end else if (state == RUN) begin
        cnt <= cnt + 6'd1;
        acc <= !is_div ? {add_s, acc[WIDTH-1:1]}
             : c[WIDTH+1] ? {add_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
             : {acc[2*WIDTH-2:0], 1'b0};
      end else if (state == FIX) begin
        done_q <= 1'b1;
        dbz_q  <= dz;
        hi_q   <= fix_hi;
        lo_q   <= fix_lo;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vector table plus control corner sequences for mult_div_unit
module tb_mult_div_unit;
  localparam int W = 32;
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  vec_t v[12];
  mult_div_unit_if #(.WIDTH(W)) bus();
  mult_div_unit #(.WIDTH(W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
  endtask
  task automatic wait_done(output int lat, output logic busy1);
    lat = -1;
    busy1 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        busy1 = bus.busy;
      end
      if (bus.done) begin
        lat = k - 1;
        break;
      end
    end
  endtask
  initial begin
    int lat, n_done;
    logic b1;
    logic [W-1:0] h, l;
    v[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    v[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    v[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    v[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    v[4]  = '{2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 1};
    v[5]  = '{2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33};
    v[6]  = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33};
    v[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    v[8]  = '{2'b11, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, 33};
    v[9]  = '{2'b10, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b1, 1};
    v[10] = '{2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 33};
    v[11] = '{2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 33};
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_done(lat, b1);
      chk($sformatf("v%0d_busy_start", i), 64'(b1), 64'd1);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(v[i].lat));
      chk($sformatf("v%0d_hi", i), 64'(bus.hi), 64'(v[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(bus.lo), 64'(v[i].lo));
      chk($sformatf("v%0d_dbz", i), 64'(bus.div_by_zero), 64'(v[i].dbz));
      chk($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 64'({bus.done, bus.div_by_zero}), 64'd0);
    end
    issue(2'b01, 32'd6, 32'd7);
    n_done = 0;
    lat = -1;
    h = 'x;
    l = 'x;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1 || k == 11) bus.start = 1'b0;
      if (k == 10) begin
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.a = 32'd9;
        bus.b = 32'd3;
      end
      if (bus.done) begin
        n_done++;
        if (lat < 0) begin
          lat = k - 1;
          h = bus.hi;
          l = bus.lo;
        end
      end
    end
    chk("busy_start_latency", 64'(lat), 64'd33);
    chk("busy_start_hi", 64'(h), 64'd0);
    chk("busy_start_lo", 64'(l), 64'd42);
    chk("busy_start_done_count", 64'(n_done), 64'd1);
    issue(2'b01, 32'd6, 32'd7);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    chk("abort_no_done", 64'(n_done), 64'd0);
    issue(2'b01, 32'd6, 32'd7);
    wait_done(lat, b1);
    chk("b2b_first_lo", 64'(bus.lo), 64'd42);
    chk("b2b_first_latency", 64'(lat), 64'd33);
    bus.start = 1'b1;
    bus.op = 2'b11;
    bus.a = 32'd9;
    bus.b = 32'd3;
    wait_done(lat, b1);
    chk("b2b_accept_busy", 64'(b1), 64'd1);
    chk("b2b_latency", 64'(lat), 64'd33);
    chk("b2b_hi", 64'(bus.hi), 64'd0);
    chk("b2b_lo", 64'(bus.lo), 64'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
